interrupt_seq: RTL

INTERRUPT_SEQ -- requirements
Module: interrupt_seq

---
 rtl/interrupt_seq.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/interrupt_seq.sv
// interrupt_seq: interrupt entry sequencer for a 6502-style core.
// Arbitrates NMI (edge), BRK (pulse) and IRQ (level) at instruction
// boundaries, hands the request to control, then walks the push/dummy
// steps and the two vector-fetch cycles.
//
// Build option: define INT_SYNC_EN to put nmi_n/irq_n through two-flop
// synchronizers (+2 cycles of input latency). Without it a single
// sampling flop is used (+1 cycle).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no entry in progress; sources evaluated on inst_boundary
// ST_REQ    | int_req asserted, waiting for int_ack from control
// ST_SEQ    | push/dummy steps 1..5; NMI may hijack IRQ/BRK here
// ST_VEC_LO | fetching vector low byte; NMI pending cleared if NMI
// ST_VEC_HI | fetching vector high byte; set_i pulsed

module interrupt_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        brk_req,
    input  logic        inst_boundary,
    input  logic        p_i,
    input  logic        int_ack,
    output logic        int_req,
    output logic [1:0]  int_type,
    output logic [2:0]  seq_step,
    output logic [15:0] vec_addr,
    output logic        b_flag,
    output logic        set_i
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_SEQ    = 3'd2,
        ST_VEC_LO = 3'd3,
        ST_VEC_HI = 3'd4
    } state_t;

    localparam logic [1:0]  TYPE_NONE = 2'b00;
    localparam logic [1:0]  TYPE_IRQ  = 2'b01;
    localparam logic [1:0]  TYPE_NMI  = 2'b10;
    localparam logic [1:0]  TYPE_BRK  = 2'b11;

    localparam logic [15:0] VEC_NMI   = 16'hFFFA;
    localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

    localparam logic [2:0]  STEP_IDLE   = 3'd0;
    localparam logic [2:0]  STEP_FIRST  = 3'd1;
    localparam logic [2:0]  STEP_LAST   = 3'd5;
    localparam logic [2:0]  STEP_VEC_LO = 3'd6;
    localparam logic [2:0]  STEP_VEC_HI = 3'd7;

    // ------------------------------------------------------------------
    // Input sampling. nmi_s_q / irq_s_q are the conditioned copies seen by
    // the detection logic; all sampling flops reset high (inactive).
    // ------------------------------------------------------------------
    logic nmi_s_q, nmi_s_d;
    logic irq_s_q, irq_s_d;

`ifdef INT_SYNC_EN
    logic nmi_m_q, nmi_m_d;
    logic irq_m_q, irq_m_d;

    // Two-stage synchronizer next values.
    always_comb begin
        nmi_m_d = nmi_n;
        irq_m_d = irq_n;
        nmi_s_d = nmi_m_q;
        irq_s_d = irq_m_q;
    end

    // Two-stage synchronizer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_m_q <= 1'b1;
            irq_m_q <= 1'b1;
            nmi_s_q <= 1'b1;
            irq_s_q <= 1'b1;
        end else begin
            nmi_m_q <= nmi_m_d;
            irq_m_q <= irq_m_d;
            nmi_s_q <= nmi_s_d;
            irq_s_q <= irq_s_d;
        end
    end
`else
    // Single sampling stage next values.
    always_comb begin
        nmi_s_d = nmi_n;
        irq_s_d = irq_n;
    end

    // Single sampling stage flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_s_q <= 1'b1;
            irq_s_q <= 1'b1;
        end else begin
            nmi_s_q <= nmi_s_d;
            irq_s_q <= irq_s_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [1:0]  int_type_q, int_type_d;
    logic [2:0]  seq_step_q, seq_step_d;
    logic        b_flag_q, b_flag_d;
    logic        nmi_pend_q, nmi_pend_d;
    logic        nmi_prev_q, nmi_prev_d;

    logic        nmi_edge;
    logic        nmi_active;
    logic        irq_active;

    // Source detection. The raw NMI edge counts as active in the same cycle
    // it is seen so NMI and IRQ have equal detection latency.
    always_comb begin
        nmi_prev_d = nmi_s_q;
        nmi_edge   = nmi_prev_q & ~nmi_s_q;
        nmi_active = nmi_pend_q | nmi_edge;
        irq_active = ~irq_s_q & ~p_i;
    end

    // State register and latched request attributes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            int_type_q <= TYPE_NONE;
            seq_step_q <= STEP_IDLE;
            b_flag_q   <= 1'b0;
            nmi_pend_q <= 1'b0;
            nmi_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            int_type_q <= int_type_d;
            seq_step_q <= seq_step_d;
            b_flag_q   <= b_flag_d;
            nmi_pend_q <= nmi_pend_d;
            nmi_prev_q <= nmi_prev_d;
        end
    end

    // Next-state logic: arbitration, handshake, step counting, NMI hijack.
    always_comb begin
        state_d    = state_q;
        int_type_d = int_type_q;
        seq_step_d = seq_step_q;
        b_flag_d   = b_flag_q;
        nmi_pend_d = nmi_pend_q | nmi_edge;

        case (state_q)
            ST_IDLE: begin
                if (inst_boundary && (nmi_active || brk_req || irq_active)) begin
                    state_d = ST_REQ;
                    if (nmi_active) begin
                        int_type_d = TYPE_NMI;
                        b_flag_d   = 1'b0;
                    end else if (brk_req) begin
                        int_type_d = TYPE_BRK;
                        b_flag_d   = 1'b1;
                    end else begin
                        int_type_d = TYPE_IRQ;
                        b_flag_d   = 1'b0;
                    end
                end
            end

            ST_REQ: begin
                // Request is latched; irq_n going away here does not cancel it.
                if (int_ack) begin
                    state_d    = ST_SEQ;
                    seq_step_d = STEP_FIRST;
                end
            end

            ST_SEQ: begin
                // A late NMI steals the vector but the pushed B bit stays.
                if (nmi_active && (int_type_q != TYPE_NMI)) begin
                    int_type_d = TYPE_NMI;
                end
                if (seq_step_q == STEP_LAST) begin
                    state_d    = ST_VEC_LO;
                    seq_step_d = STEP_VEC_LO;
                end else begin
                    seq_step_d = seq_step_q + 3'd1;
                end
            end

            ST_VEC_LO: begin
                // Consume the pending NMI; a fresh edge this cycle survives.
                if (int_type_q == TYPE_NMI) begin
                    nmi_pend_d = nmi_edge;
                end
                state_d    = ST_VEC_HI;
                seq_step_d = STEP_VEC_HI;
            end

            ST_VEC_HI: begin
                state_d    = ST_IDLE;
                seq_step_d = STEP_IDLE;
                int_type_d = TYPE_NONE;
                b_flag_d   = 1'b0;
            end

            default: begin
                state_d    = ST_IDLE;
                seq_step_d = STEP_IDLE;
                int_type_d = TYPE_NONE;
                b_flag_d   = 1'b0;
            end
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        int_req  = (state_q == ST_REQ);
        int_type = int_type_q;
        seq_step = seq_step_q;
        b_flag   = b_flag_q;
        set_i    = (state_q == ST_VEC_HI);
        vec_addr = 16'h0000;
        case (state_q)
            ST_VEC_LO: vec_addr = (int_type_q == TYPE_NMI) ? VEC_NMI : VEC_IRQ;
            ST_VEC_HI: vec_addr = ((int_type_q == TYPE_NMI) ? VEC_NMI : VEC_IRQ) + 16'h0001;
            default:   vec_addr = 16'h0000;
        endcase
    end

endmodule
